mpu_axis_capture: RTL and testbench

- Parametrised multi-channel capture stage between the MPU6050 register sequencer and the board LEDs / downstream logic.
- Generates the shared TIC strobe and collects the byte stream (LOAD/ADR/DATA) into NUM_CH signed 16-bit samples.
- Publishes each completed frame through a valid/ready handshake and drives per-channel threshold LEDs with hysteresis.
- Supersedes the single 8-bit X-register capture and its separate comparator.

---
 rtl/mpu_pkg.sv | 31 +++
 rtl/mpu_hyst_cmp.sv | 46 ++++
 rtl/mpu_axis_capture.sv | 130 +++++++++++++
 tb/tb_mpu_axis_capture.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU6050 capture stage: FSM encoding, register map, sample width.
package mpu_pkg;

  localparam int CH_W = 16;

  typedef enum logic [1:0] {
    COLLECT     = 2'd0,
    PUBLISH     = 2'd1,
    RESCAN_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] ADR_X_H = 4'd0;
  localparam logic [3:0] ADR_X_L = 4'd1;
  localparam logic [3:0] ADR_Y_H = 4'd2;
  localparam logic [3:0] ADR_Y_L = 4'd3;
  localparam logic [3:0] ADR_Z_H = 4'd4;
  localparam logic [3:0] ADR_Z_L = 4'd5;

  // |s| widened to 17 bits; the most negative code saturates to 32767.
  function automatic logic [CH_W:0] sat_mag(input logic [CH_W-1:0] s);
    logic [CH_W-1:0] neg;
    neg = ~s + 16'd1;
    if (s == 16'h8000)
      sat_mag = 17'd32767;
    else if (s[CH_W-1])
      sat_mag = {1'b0, neg};
    else
      sat_mag = {1'b0, s};
  endfunction

endpackage

// File: rtl/mpu_hyst_cmp.sv
// One channel's threshold LED with hysteresis plus its sign bit, both registered on publish.
module mpu_hyst_cmp
  import mpu_pkg::*;
#(
  parameter logic [CH_W-1:0] THRESH = 16'd8192,
  parameter logic [CH_W-1:0] HYST   = 16'd1024
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_upd,
  input  logic [CH_W-1:0] i_sample,
  output logic            o_led,
  output logic            o_sign
);

  logic [CH_W:0] w_mag;
  logic [CH_W:0] w_on_lvl;
  logic [CH_W:0] w_off_lvl;
  logic          w_on;
  logic          w_off;
  logic          r_led;
  logic          r_sign;

  assign w_mag     = sat_mag(i_sample);
  assign w_on_lvl  = {1'b0, THRESH};
  assign w_off_lvl = {1'b0, THRESH} - {1'b0, HYST};
  assign w_on      = (w_mag >= w_on_lvl);
  assign w_off     = (w_mag < w_off_lvl);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led  <= 1'b0;
      r_sign <= 1'b0;
    end else if (i_upd) begin
      if (w_on)
        r_led <= 1'b1;
      else if (w_off)
        r_led <= 1'b0;
      r_sign <= i_sample[CH_W-1];
    end
  end

  assign o_led  = r_led;
  assign o_sign = r_sign;

endmodule

// File: rtl/mpu_axis_capture.sv
// Captures the sequencer byte stream into NUM_CH signed samples on a shared TIC strobe,
// publishes frames over valid/ready, and drives per-channel hysteresis LEDs.
module mpu_axis_capture
  import mpu_pkg::*;
#(
  parameter int              TIC_DIV = 161,
  parameter int              NUM_CH  = 3,
  parameter logic [CH_W-1:0] THRESH  = 16'd8192,
  parameter logic [CH_W-1:0] HYST    = 16'd1024
) (
  input  logic                     i_mclk,
  input  logic                     i_nrst,
  output logic                     o_tic,
  input  logic                     i_load,
  input  logic [3:0]               i_adr,
  input  logic [7:0]               i_data,
  input  logic                     i_completed,
  output logic                     o_rescan,
  output logic [CH_W*NUM_CH-1:0]   o_sample,
  output logic                     o_frame_valid,
  input  logic                     i_frame_ready,
  output logic [7:0]               o_frame_cnt,
  output logic                     o_overrun,
  input  logic                     i_clr_ovr,
  output logic [NUM_CH-1:0]        o_led,
  output logic [NUM_CH-1:0]        o_sign
);

  logic [15:0]              r_tic_cnt;
  logic                     w_tic;
  logic [CH_W*NUM_CH-1:0]   r_shadow;
  logic [CH_W*NUM_CH-1:0]   r_sample;
  state_t                   r_state;
  logic                     r_rescan;
  logic                     r_valid;
  logic [7:0]               r_cnt;
  logic                     r_ovr;
  logic                     w_pub_ok;

  assign w_tic = (r_tic_cnt == 16'(TIC_DIV - 1));

  always_ff @(posedge i_mclk or negedge i_nrst) begin
    if (!i_nrst)
      r_tic_cnt <= '0;
    else if (w_tic)
      r_tic_cnt <= '0;
    else
      r_tic_cnt <= r_tic_cnt + 16'd1;
  end

  // Even ADR is the high byte of channel ADR/2, odd ADR the low byte; out-of-range ADR matches nothing.
  always_ff @(posedge i_mclk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_shadow <= '0;
    end else if (w_tic && i_load) begin
      for (int b = 0; b < 2*NUM_CH; b++) begin
        if (int'(i_adr) == b)
          r_shadow[CH_W*(b/2) + ((b % 2 == 0) ? 8 : 0) +: 8] <= i_data;
      end
    end
  end

  assign w_pub_ok = (r_state == PUBLISH) && (!r_valid || i_frame_ready);

  // A successful publish overrides the handshake clear; a drop overrides CLR_OVR.
  always_ff @(posedge i_mclk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state  <= COLLECT;
      r_rescan <= 1'b0;
      r_valid  <= 1'b0;
      r_sample <= '0;
      r_cnt    <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (r_valid && i_frame_ready)
        r_valid <= 1'b0;
      if (i_clr_ovr)
        r_ovr <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_tic && i_completed)
            r_state <= PUBLISH;
        end
        PUBLISH: begin
          if (w_pub_ok) begin
            r_sample <= r_shadow;
            r_valid  <= 1'b1;
            r_cnt    <= r_cnt + 8'd1;
          end else begin
            r_ovr <= 1'b1;
          end
          r_state  <= RESCAN_WAIT;
          r_rescan <= 1'b1;
        end
        RESCAN_WAIT: begin
          if (w_tic) begin
            r_state  <= COLLECT;
            r_rescan <= 1'b0;
          end
        end
        default: begin
          r_state  <= COLLECT;
          r_rescan <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mpu_hyst_cmp #(
      .THRESH (THRESH),
      .HYST   (HYST)
    ) u_cmp (
      .i_clk    (i_mclk),
      .i_rst_n  (i_nrst),
      .i_upd    (w_pub_ok),
      .i_sample (r_shadow[CH_W*g +: CH_W]),
      .o_led    (o_led[g]),
      .o_sign   (o_sign[g])
    );
  end

  assign o_tic         = w_tic;
  assign o_rescan      = r_rescan;
  assign o_sample      = r_sample;
  assign o_frame_valid = r_valid;
  assign o_frame_cnt   = r_cnt;
  assign o_overrun     = r_ovr;

endmodule

// File: tb/tb_mpu_axis_capture.sv
// Directed self-checking bench for mpu_axis_capture (NUM_CH=3, shortened TIC period).
module tb_mpu_axis_capture;

  localparam int TIC_DIV = 41;
  localparam int NUM_CH  = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        tic;
  logic        load = 1'b0;
  logic [3:0]  adr = 4'd0;
  logic [7:0]  data = 8'd0;
  logic        completed = 1'b0;
  logic        rescan;
  logic [47:0] sample;
  logic        fvalid;
  logic        fready = 1'b0;
  logic [7:0]  fcnt;
  logic        ovr;
  logic        clr_ovr = 1'b0;
  logic [2:0]  led;
  logic [2:0]  sign;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_cnt = 8'd0;

  mpu_axis_capture #(
    .TIC_DIV (TIC_DIV),
    .NUM_CH  (NUM_CH),
    .THRESH  (16'd8192),
    .HYST    (16'd1024)
  ) dut (
    .i_mclk        (clk),
    .i_nrst        (nrst),
    .o_tic         (tic),
    .i_load        (load),
    .i_adr         (adr),
    .i_data        (data),
    .i_completed   (completed),
    .o_rescan      (rescan),
    .o_sample      (sample),
    .o_frame_valid (fvalid),
    .i_frame_ready (fready),
    .o_frame_cnt   (fcnt),
    .o_overrun     (ovr),
    .i_clr_ovr     (clr_ovr),
    .o_led         (led),
    .o_sign        (sign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tic();
    int n = 0;
    while (tic !== 1'b1 && n < TIC_DIV + 4) begin
      step();
      n++;
    end
    checks++;
    if (tic !== 1'b1) begin
      errors++;
      $display("FAIL wait_tic: tic=%b required=1 within %0d cycles", tic, n);
    end
  endtask

  task automatic wait_rescan_low();
    int n = 0;
    while (rescan !== 1'b0 && n < 2*TIC_DIV + 4) begin
      step();
      n++;
    end
    checks++;
    if (rescan !== 1'b0) begin
      errors++;
      $display("FAIL wait_rescan_low: rescan=%b required=0 within %0d cycles", rescan, n);
    end
  endtask

  task automatic send_byte(input logic [3:0] a, input logic [7:0] d);
    wait_tic();
    load = 1'b1;
    adr  = a;
    data = d;
    step();
    load = 1'b0;
  endtask

  // Returns positioned inside the PUBLISH cycle.
  task automatic do_complete();
    wait_rescan_low();
    wait_tic();
    completed = 1'b1;
    step();
    completed = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int m;
    nrst = 1'b0;
    step();
    step();
    checks++;
    if ({tic, rescan, fvalid, ovr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: tic/rescan/valid/ovr=%b required=0000", {tic, rescan, fvalid, ovr});
    end
    checks++;
    if (sample !== 48'd0 || fcnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: sample=%h cnt=%0d required 0/0", sample, fcnt);
    end
    checks++;
    if ({led, sign} !== 6'd0) begin
      errors++;
      $display("FAIL reset_led_sign: led=%b sign=%b required 000/000", led, sign);
    end
    nrst = 1'b1;
    n = 0;
    while (tic !== 1'b1 && n < TIC_DIV + 4) begin
      step();
      n++;
    end
    checks++;
    if (n !== TIC_DIV - 1) begin
      errors++;
      $display("FAIL tic_first: first tic at cycle %0d required %0d", n, TIC_DIV - 1);
    end
    step();
    checks++;
    if (tic !== 1'b0) begin
      errors++;
      $display("FAIL tic_width: tic=%b one cycle after pulse, required 0", tic);
    end
    m = 1;
    while (tic !== 1'b1 && m < TIC_DIV + 4) begin
      step();
      m++;
    end
    checks++;
    if (m !== TIC_DIV) begin
      errors++;
      $display("FAIL tic_period: period=%0d required %0d", m, TIC_DIV);
    end
  endtask

  task automatic test_frame();
    fready = 1'b1;
    send_byte(4'd0, 8'h12);
    send_byte(4'd1, 8'h34);
    send_byte(4'd2, 8'hFF);
    send_byte(4'd3, 8'hFE);
    send_byte(4'd4, 8'h80);
    send_byte(4'd5, 8'h00);
    do_complete();
    checks++;
    if (rescan !== 1'b0 || fvalid !== 1'b0) begin
      errors++;
      $display("FAIL frame_publish_cycle: rescan=%b valid=%b required 0/0", rescan, fvalid);
    end
    step();
    exp_cnt = 8'd1;
    checks++;
    if (sample !== 48'h8000_FFFE_1234) begin
      errors++;
      $display("FAIL frame_sample: sample=%h required 8000fffe1234", sample);
    end
    checks++;
    if (fvalid !== 1'b1 || fcnt !== exp_cnt) begin
      errors++;
      $display("FAIL frame_valid_cnt: valid=%b cnt=%0d required 1/%0d", fvalid, fcnt, exp_cnt);
    end
    checks++;
    if (sign !== 3'b110 || led !== 3'b100) begin
      errors++;
      $display("FAIL frame_sign_led: sign=%b led=%b required 110/100", sign, led);
    end
    checks++;
    if (rescan !== 1'b1) begin
      errors++;
      $display("FAIL frame_rescan_set: rescan=%b required 1", rescan);
    end
    step();
    checks++;
    if (fvalid !== 1'b0 || rescan !== 1'b1) begin
      errors++;
      $display("FAIL frame_valid_pulse: valid=%b rescan=%b required 0/1", fvalid, rescan);
    end
    wait_tic();
    checks++;
    if (rescan !== 1'b1) begin
      errors++;
      $display("FAIL rescan_at_tic: rescan=%b required 1", rescan);
    end
    step();
    checks++;
    if (rescan !== 1'b0) begin
      errors++;
      $display("FAIL rescan_after_tic: rescan=%b required 0", rescan);
    end
  endtask

  task automatic test_backpressure();
    fready = 1'b0;
    send_byte(4'd0, 8'h00);
    send_byte(4'd1, 8'h05);
    do_complete();
    step();
    exp_cnt = 8'd2;
    checks++;
    if (fvalid !== 1'b1 || sample !== 48'h8000_FFFE_0005 || fcnt !== exp_cnt) begin
      errors++;
      $display("FAIL bp_first: valid=%b sample=%h cnt=%0d required 1/8000fffe0005/%0d", fvalid, sample, fcnt, exp_cnt);
    end
    send_byte(4'd0, 8'h11);
    do_complete();
    step();
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun: overrun=%b required 1", ovr);
    end
    checks++;
    if (sample !== 48'h8000_FFFE_0005 || fcnt !== exp_cnt || fvalid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: sample=%h cnt=%0d valid=%b required 8000fffe0005/%0d/1", sample, fcnt, fvalid, exp_cnt);
    end
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear: overrun=%b required 0", ovr);
    end
    send_byte(4'd1, 8'h22);
    do_complete();
    fready = 1'b1;
    step();
    fready = 1'b0;
    exp_cnt = 8'd3;
    checks++;
    if (fvalid !== 1'b1 || sample !== 48'h8000_FFFE_1122 || fcnt !== exp_cnt) begin
      errors++;
      $display("FAIL bp_ready_in_publish: valid=%b sample=%h cnt=%0d required 1/8000fffe1122/%0d", fvalid, sample, fcnt, exp_cnt);
    end
    do_complete();
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    checks++;
    if (ovr !== 1'b1 || fcnt !== exp_cnt) begin
      errors++;
      $display("FAIL bp_set_wins: overrun=%b cnt=%0d required 1/%0d", ovr, fcnt, exp_cnt);
    end
    clr_ovr = 1'b1;
    fready  = 1'b1;
    step();
    clr_ovr = 1'b0;
    checks++;
    if (ovr !== 1'b0 || fvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: overrun=%b valid=%b required 0/0", ovr, fvalid);
    end
  endtask

  task automatic test_hysteresis();
    logic [15:0] vals [5];
    logic [4:0]  exp_led;
    logic [4:0]  exp_sign;
    logic [15:0] v;
    vals[0] = 16'd8191;
    vals[1] = 16'd8192;
    vals[2] = 16'd7200;
    vals[3] = 16'd7167;
    vals[4] = 16'h8000;
    exp_led  = 5'b10110;
    exp_sign = 5'b10000;
    fready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v = vals[i];
      send_byte(4'd0, v[15:8]);
      send_byte(4'd1, v[7:0]);
      do_complete();
      step();
      exp_cnt = exp_cnt + 8'd1;
      checks++;
      if (led[0] !== exp_led[i] || sign[0] !== exp_sign[i]) begin
        errors++;
        $display("FAIL hyst_%0d: value=%h led0=%b sign0=%b required %b/%b", i, v, led[0], sign[0], exp_led[i], exp_sign[i]);
      end
    end
  endtask

  task automatic test_ignored_and_wrap();
    fready = 1'b1;
    send_byte(4'd7, 8'hAA);
    send_byte(4'd6, 8'h55);
    do_complete();
    step();
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (sample !== 48'h8000_FFFE_8000 || fcnt !== exp_cnt) begin
      errors++;
      $display("FAIL ignored_adr: sample=%h cnt=%0d required 8000fffe8000/%0d", sample, fcnt, exp_cnt);
    end
    for (int i = 0; i < 300 && exp_cnt != 8'd0; i++) begin
      do_complete();
      step();
      exp_cnt = exp_cnt + 8'd1;
      if (exp_cnt == 8'd255) begin
        checks++;
        if (fcnt !== 8'd255) begin
          errors++;
          $display("FAIL cnt_255: cnt=%0d required 255", fcnt);
        end
      end
    end
    checks++;
    if (fcnt !== 8'd0 || fvalid !== 1'b1) begin
      errors++;
      $display("FAIL cnt_wrap: cnt=%0d valid=%b required 0/1", fcnt, fvalid);
    end
  endtask

  task automatic test_reset_mid();
    fready = 1'b0;
    step();
    do_complete();
    step();
    checks++;
    if (rescan !== 1'b1 || fvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_precond: rescan=%b valid=%b required 1/1", rescan, fvalid);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if ({tic, rescan, fvalid, ovr} !== 4'b0000 || sample !== 48'd0 || fcnt !== 8'd0 || {led, sign} !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset: tic/rescan/valid/ovr=%b sample=%h cnt=%0d led=%b sign=%b required all 0",
               {tic, rescan, fvalid, ovr}, sample, fcnt, led, sign);
    end
    step();
    step();
    nrst   = 1'b1;
    fready = 1'b1;
    send_byte(4'd0, 8'h0A);
    send_byte(4'd1, 8'h0B);
    do_complete();
    step();
    checks++;
    if (sample !== 48'h0000_0000_0A0B || fcnt !== 8'd1 || fvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_resume: sample=%h cnt=%0d valid=%b required 000000000a0b/1/1", sample, fcnt, fvalid);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_hysteresis();
    test_ignored_and_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
